// File: rtl/preg_free_list_pkg.sv
// Shared definitions for the physical-register free list.
// Holds the width-derivation helpers, the default pool sizing, the preg tag
// type and a small wrap-around helper used by the pointer logic.
package preg_free_list_pkg;

    // Default pool sizing. Pregs 0..NUM_ARCH_RST-1 hold the reset mappings.
    localparam int NUM_PREGS_DEF = 64;
    localparam int NUM_ARCH_RST  = 32;

    // Width of a tag able to name any of n registers (at least 1 bit).
    function automatic int tag_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold 0..cap inclusive.
    function automatic int cnt_w_f(input int cap);
        return $clog2(cap + 1);
    endfunction

    // Width of a pointer into a cap-entry ring (at least 1 bit).
    function automatic int ptr_w_f(input int cap);
        return (cap > 1) ? $clog2(cap) : 1;
    endfunction

    // Successor of p in a ring of depth entries (depth need not be 2^n).
    function automatic int unsigned wrap_next(input int unsigned p,
                                              input int unsigned depth);
        return (p + 1 >= depth) ? 0 : p + 1;
    endfunction

    localparam int TAG_W = tag_w_f(NUM_PREGS_DEF);

    typedef logic [TAG_W-1:0] preg_tag_t;

endpackage

// File: rtl/preg_free_list_circ_ptr.sv
// Circular pointer into a DEPTH-entry ring.
// Ports:
//   clk, rst_aH : clock and asynchronous active-high reset (ptr -> 0)
//   inc         : advance by one, wrapping DEPTH-1 -> 0
//   load        : overwrite with load_val (takes priority over inc)
//   load_val    : value loaded when load is high
//   ptr         : current pointer value
module circ_ptr
    import preg_free_list_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int W     = ptr_w_f(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_aH,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= (ptr == W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/preg_free_list.sv
// Rename-stage physical register free list.
// A circular list of CAP = NUM_PREGS-NUM_ARCH free tags with three pointers:
// head (speculative, advanced by rename), chead (advanced as allocations
// retire) and tail (advanced as stale mappings are returned at commit).
// A flush rewinds head to chead, returning every uncommitted allocation.
// Ports:
//   clk, rst_aH  : clock, asynchronous active-high reset
//   alloc_req    : rename wants one preg this cycle
//   alloc_valid  : a free preg is available and no flush is active
//   alloc_tag    : preg granted when alloc_req && alloc_valid
//   commit_valid : oldest outstanding allocation retired
//   free_valid   : return free_tag to the list
//   free_tag     : preg being returned
//   flush        : squash all uncommitted allocations
//   free_count   : speculative free entries
//   err          : sticky protocol-violation flag
module preg_free_list
    import preg_free_list_pkg::*;
#(
    parameter int NUM_PREGS = NUM_PREGS_DEF,
    parameter int NUM_ARCH  = NUM_ARCH_RST,
    parameter int CAP       = NUM_PREGS - NUM_ARCH,
    parameter int TAG_W     = tag_w_f(NUM_PREGS),
    parameter int CNT_W     = cnt_w_f(CAP)
) (
    input  logic             clk,
    input  logic             rst_aH,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             commit_valid,
    input  logic             free_valid,
    input  logic [TAG_W-1:0] free_tag,
    input  logic             flush,
    output logic [CNT_W-1:0] free_count,
    output logic             err
);

    localparam int PTR_W = ptr_w_f(CAP);

    logic [TAG_W-1:0] entries [CAP];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] chead;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] spec_cnt;
    logic [CNT_W-1:0] arch_cnt;

    logic             fire;
    logic             commit_ok;
    logic             free_ok;
    logic             commit_bad;
    logic             free_bad;
    logic [CNT_W-1:0] arch_next;
    logic [CNT_W-1:0] spec_next;
    logic [PTR_W-1:0] head_load;

    assign alloc_valid = (spec_cnt != '0) && !flush;
    assign alloc_tag   = entries[head];
    assign free_count  = spec_cnt;
    assign fire        = alloc_req && alloc_valid;

    // A commit with nothing outstanding is only legal when the allocation it
    // retires is being granted in the same cycle.
    assign commit_bad = commit_valid && (arch_cnt == spec_cnt) && !fire;
    assign commit_ok  = commit_valid && !commit_bad;
    assign free_bad   = free_valid && (arch_cnt == CNT_W'(CAP));
    assign free_ok    = free_valid && !free_bad;

    assign arch_next = arch_cnt + CNT_W'(free_ok) - CNT_W'(commit_ok);
    // On flush every uncommitted allocation returns to the list, so the
    // speculative view collapses onto the committed one.
    assign spec_next = flush ? arch_next
                             : spec_cnt + CNT_W'(free_ok) - CNT_W'(fire);

    // Rewinding head must account for a retirement landing in the same cycle.
    assign head_load = commit_ok ? PTR_W'(wrap_next(int'(chead), CAP)) : chead;

    circ_ptr #(.DEPTH(CAP), .W(PTR_W)) u_head (
        .clk      (clk),
        .rst_aH   (rst_aH),
        .inc      (fire),
        .load     (flush),
        .load_val (head_load),
        .ptr      (head)
    );

    circ_ptr #(.DEPTH(CAP), .W(PTR_W)) u_chead (
        .clk      (clk),
        .rst_aH   (rst_aH),
        .inc      (commit_ok),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (chead)
    );

    circ_ptr #(.DEPTH(CAP), .W(PTR_W)) u_tail (
        .clk      (clk),
        .rst_aH   (rst_aH),
        .inc      (free_ok),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (tail)
    );

    // Entry storage: reset contents are the first non-architectural pregs.
    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            for (int i = 0; i < CAP; i++) begin
                entries[i] <= TAG_W'(NUM_ARCH + i);
            end
        end else if (free_ok) begin
            entries[tail] <= free_tag;
        end
    end

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            spec_cnt <= CNT_W'(CAP);
            arch_cnt <= CNT_W'(CAP);
            err      <= 1'b0;
        end else begin
            spec_cnt <= spec_next;
            arch_cnt <= arch_next;
            if (commit_bad || free_bad) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_preg_free_list.sv
// Self-checking bench for preg_free_list (NUM_PREGS=64, NUM_ARCH=32).
// The reference model keeps the committed free list as a queue of tags plus
// a count of speculatively consumed entries at its front.
module tb_preg_free_list;
    import preg_free_list_pkg::*;

    localparam int CAP = 32;

    logic       clk = 1'b0;
    logic       rst_aH = 1'b1;
    logic       alloc_req = 1'b0;
    logic       alloc_valid;
    preg_tag_t  alloc_tag;
    logic       commit_valid = 1'b0;
    logic       free_valid = 1'b0;
    preg_tag_t  free_tag = '0;
    logic       flush = 1'b0;
    logic [5:0] free_count;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;

    preg_free_list #(.NUM_PREGS(64), .NUM_ARCH(32)) dut (
        .clk          (clk),
        .rst_aH       (rst_aH),
        .alloc_req    (alloc_req),
        .alloc_valid  (alloc_valid),
        .alloc_tag    (alloc_tag),
        .commit_valid (commit_valid),
        .free_valid   (free_valid),
        .free_tag     (free_tag),
        .flush        (flush),
        .free_count   (free_count),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_q[$];      // committed free list, front = oldest
    int m_out;       // entries at the front consumed speculatively
    bit m_err;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < CAP; i++) m_q.push_back(32 + i);
        m_out = 0;
        m_err = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst_aH);
            if (rst_aH) begin
                model_reset();
            end else begin
                int avail;
                int sz0;
                int o;
                bit fire;
                sz0   = m_q.size();
                avail = sz0 - m_out;
                fire  = alloc_req && (avail > 0) && !flush;
                o     = m_out + int'(fire);
                if (commit_valid) begin
                    if (o > 0) begin
                        void'(m_q.pop_front());
                        o--;
                    end else begin
                        m_err = 1;
                    end
                end
                if (free_valid) begin
                    if (sz0 >= CAP) m_err = 1;
                    else m_q.push_back(int'(free_tag));
                end
                if (flush) o = 0;
                m_out = o;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            begin
                int ecnt;
                ecnt = m_q.size() - m_out;
                chk("mon_free_count", int'(free_count), ecnt);
                chk("mon_alloc_valid", int'(alloc_valid), int'((ecnt > 0) && !flush));
                chk("mon_err", int'(err), int'(m_err));
                if (ecnt > 0) chk("mon_alloc_tag", int'(alloc_tag), m_q[m_out]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Apply one cycle of inputs; returns at the following negedge so the
    // caller can check outputs seen while these inputs are applied.
    task automatic drive(input bit a, input bit c, input bit f,
                         input int t, input bit fl);
        @(posedge clk);
        #1;
        alloc_req    = a;
        commit_valid = c;
        free_valid   = f;
        free_tag     = preg_tag_t'(t);
        flush        = fl;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_aH       = 1'b1;
        alloc_req    = 1'b0;
        commit_valid = 1'b0;
        free_valid   = 1'b0;
        free_tag     = '0;
        flush        = 1'b0;
        @(negedge clk);
        chk("rst_alloc_valid", int'(alloc_valid), 1);
        chk("rst_alloc_tag", int'(alloc_tag), 32);
        chk("rst_free_count", int'(free_count), 32);
        chk("rst_err", int'(err), 0);
        @(posedge clk);
        #2;
        rst_aH = 1'b0;
    endtask

    initial begin
        // Watchdog so the run always ends.
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // 1) Drain the whole list with paired commits: tags 32..63 in order.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1, 1, 0, 0, 0);
            chk("drain_tag", int'(alloc_tag), 32 + i);
        end
        idle();
        chk("drain_empty_valid", int'(alloc_valid), 0);
        chk("drain_empty_count", int'(free_count), 0);

        // 2) Free into an empty list with alloc_req held: no bypass.
        drive(1, 0, 1, 5, 0);
        chk("nobypass_valid", int'(alloc_valid), 0);
        drive(1, 0, 0, 0, 0);
        chk("nobypass_next_valid", int'(alloc_valid), 1);
        chk("nobypass_next_tag", int'(alloc_tag), 5);
        idle();
        chk("nobypass_after_valid", int'(alloc_valid), 0);
        chk("nobypass_err", int'(err), 0);

        // 3) Alloc 10, commit 4, flush -> resume at 36 with 28 free.
        do_reset();
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        chk("flush_valid_low", int'(alloc_valid), 0);
        idle();
        chk("flush_tag", int'(alloc_tag), 36);
        chk("flush_count", int'(free_count), 28);
        drive(1, 0, 0, 0, 0);
        chk("flush_realloc0", int'(alloc_tag), 36);
        drive(1, 0, 0, 0, 0);
        chk("flush_realloc1", int'(alloc_tag), 37);
        idle();

        // 4) Flush with alloc_req and commit after 3 allocs.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1);
        chk("flushc_valid_low", int'(alloc_valid), 0);
        idle();
        chk("flushc_tag", int'(alloc_tag), 33);
        chk("flushc_count", int'(free_count), 31);

        // 5) Wrap-around: 31 alloc+commit, free 7,8,9, then alloc 4.
        do_reset();
        for (int i = 0; i < 31; i++) drive(1, 1, 0, 0, 0);
        drive(0, 0, 1, 7, 0);
        drive(0, 0, 1, 8, 0);
        drive(0, 0, 1, 9, 0);
        drive(1, 0, 0, 0, 0);
        chk("wrap_tag0", int'(alloc_tag), 63);
        drive(1, 0, 0, 0, 0);
        chk("wrap_tag1", int'(alloc_tag), 7);
        drive(1, 0, 0, 0, 0);
        chk("wrap_tag2", int'(alloc_tag), 8);
        drive(1, 0, 0, 0, 0);
        chk("wrap_tag3", int'(alloc_tag), 9);
        idle();
        chk("wrap_count", int'(free_count), 0);
        chk("wrap_err", int'(err), 0);

        // 6) Illegal free on a full list, then async reset mid-sequence.
        do_reset();
        drive(0, 0, 1, 3, 0);
        idle();
        chk("overfree_err", int'(err), 1);
        chk("overfree_count", int'(free_count), 32);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        alloc_req = 1'b0;
        rst_aH    = 1'b1;
        #1;
        chk("async_rst_err", int'(err), 0);
        chk("async_rst_tag", int'(alloc_tag), 32);
        chk("async_rst_count", int'(free_count), 32);
        @(posedge clk);
        #2;
        rst_aH = 1'b0;

        // 7) Commit with nothing outstanding is flagged.
        idle();
        drive(0, 1, 0, 0, 0);
        idle();
        chk("undercommit_err", int'(err), 1);
        chk("undercommit_count", int'(free_count), 32);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Rename-stage allocator for the physical register pool; shares the pool of NUM_PREGS registers between the rename stage (allocate) and the commit stage (return).
- Implements a circular free list with three pointers:
  - speculative head: advanced by rename.
  - commit head: advanced by in-order retirement of allocations.
  - tail: advanced by frees of old mappings at commit.
- Pipeline flush restores the speculative head from the commit head. No checkpoints.

Parameters:
NUM_PREGS, 64, total physical registers
NUM_ARCH, 32, architectural registers; pregs 0..NUM_ARCH-1 are mapped at reset and never start on the list
(derived) CAP = NUM_PREGS-NUM_ARCH, TAG_W = $clog2(NUM_PREGS), CNT_W = $clog2(CAP+1)

Ports:
clk  in  1  clock, rising edge
rst_aH  in  1  asynchronous reset, active-high
alloc_req  in  1  rename wants one preg this cycle
alloc_valid  out  1  a free preg is available and no flush is active
alloc_tag  out  TAG_W  preg granted when alloc_req && alloc_valid
commit_valid  in  1  oldest outstanding allocation retired
free_valid  in  1  return free_tag (stale mapping of a retiring instr)
free_tag  in  TAG_W  preg being returned
flush  in  1  squash all uncommitted allocations
free_count  out  CNT_W  speculative free entries (spec_cnt)
err  out  1  sticky protocol-violation flag

Behaviour:
- State:
  - entries[CAP] of TAG_W.
  - Pointers head, chead, tail, each $clog2(CAP) bits wide, each wrapping CAP-1 -> 0 (CAP need not be a power of 2).
  - Counters spec_cnt (head..tail) and arch_cnt (chead..tail), each CNT_W bits.
- Reset (async, rst_aH=1):
  - entries[i] = NUM_ARCH+i.
  - head = chead = tail = 0.
  - spec_cnt = arch_cnt = CAP.
  - err = 0.
  - Resulting outputs: alloc_valid = 1, alloc_tag = NUM_ARCH, free_count = CAP.
  - Reset asserted mid-operation discards all state immediately.
- alloc_tag = entries[head], combinational, zero latency.
- alloc_valid = (spec_cnt != 0) && !flush.
- alloc fire = alloc_req && alloc_valid: head++, spec_cnt--.
- commit_valid: chead++, arch_cnt--.
- free_valid: entries[tail] <= free_tag, tail++, spec_cnt++, arch_cnt++.
- Simultaneous events, applied in one cycle:
  - alloc+free: spec_cnt unchanged.
  - commit+free: arch_cnt unchanged.
  - When spec_cnt==0, a free in the same cycle is not visible to alloc until the next cycle (no bypass).
- Flush:
  - head <= chead, incremented by 1 if commit_valid in the same cycle.
  - spec_cnt <= next arch_cnt, including same-cycle commit and free.
  - Same-cycle alloc_req is ignored, because alloc_valid is forced 0.
  - Same-cycle free is honoured.
- Invariant: arch_cnt >= spec_cnt. Outstanding allocations = arch_cnt - spec_cnt.
- err is set (sticky until reset) on any of:
  - free_valid when arch_cnt==CAP: the free is dropped.
  - commit_valid when arch_cnt==spec_cnt and no alloc in the same cycle: the commit is dropped.
  - free_tag < NUM_ARCH on a free is NOT checked (architectural regs can legally be freed after remap).
- No duplicate-tag detection; that is the caller's responsibility.

Decomposition:
- Shared package holds:
  - TAG_W / CNT_W derivation functions.
  - preg_tag_t typedef.
  - Reset-content constant NUM_ARCH.
- One sub-module, circ_ptr (params DEPTH; ports clk, rst_aH, inc, load, load_val, ptr), instantiated three times for head, chead and tail.
- Counter logic stays in the top module.

Test Plan:
- Reset, then 32 back-to-back allocs (NUM_PREGS=64) -> tags 32..63 in order; after the 32nd alloc, alloc_valid = 0 and free_count = 0.
- Empty list, free_tag=5 with alloc_req held -> alloc_valid = 0 in that cycle; next cycle alloc_valid = 1 and alloc_tag = 5.
- Alloc 10 (tags 32..41), commit 4, flush -> alloc_tag = 36, free_count = 28; allocating again yields 36, 37, ...
- Flush together with alloc_req and commit_valid after 3 allocs -> no tag consumed; head = 1; alloc_tag = 33; free_count = 31.
- Alloc 31 times after reset, then free 3 times (tags 7, 8, 9) -> alloc yields 63, 7, 8, 9 (wrap-around past entry CAP-1); then free_count = 0.
- Free with arch_cnt==CAP at reset -> err = 1 and free_count stays 32; assert rst_aH mid-sequence -> err = 0 and alloc_tag = 32 immediately.
